// File: rtl/naive_bus_arbiter2_if.sv
// naive_bus point-to-point link: independent read and write request channels.
// The master modport issues requests; the slave modport grants and returns read data.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/naive_bus_arbiter2.sv
// Two-master / one-slave naive_bus arbiter; read and write channels arbitrated independently.
// Define NAIVE_BUS_ARB_RR_EN for round-robin; otherwise master 0 has fixed priority.

// One channel: combinational winner, lock held across slave stalls, priority pointer.
module naive_bus_arb_ch (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       gnt,
  output logic       win
);
  typedef enum logic {IDLE, HELD} state_t;

  state_t state;
  logic   sel;
  logic   prio;

  always_comb begin
    win = prio;
    if (state == HELD)        win = sel;
    else if (req[0] ^ req[1]) win = req[1];
  end

  // A held master that drops its request abandons the lock without a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req[win] && !gnt) begin
          state <= HELD;
          sel   <= win;
        end
        HELD: if (gnt || !req[sel]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NAIVE_BUS_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 prio <= 1'b0;
    else if (req[win] && gnt) prio <= ~win;
  end
`else
  assign prio = 1'b0;
`endif
endmodule

module naive_bus_arbiter2 (
  input  logic clk,
  input  logic rst,
  naive_bus.slave  s0,
  naive_bus.slave  s1,
  naive_bus.master m
);
  logic [1:0]        rd_req, wr_req;
  logic [1:0][3:0]   rd_be, wr_be;
  logic [1:0][31:0]  rd_addr, wr_addr, wr_data;
  logic [1:0][1:0]   ch_req;
  logic [1:0]        ch_gnt, ch_win;
  logic              rw, ww;
  logic              rd_own_v, rd_own;

  assign rd_req  = {s1.rd_req,  s0.rd_req};
  assign rd_be   = {s1.rd_be,   s0.rd_be};
  assign rd_addr = {s1.rd_addr, s0.rd_addr};
  assign wr_req  = {s1.wr_req,  s0.wr_req};
  assign wr_be   = {s1.wr_be,   s0.wr_be};
  assign wr_addr = {s1.wr_addr, s0.wr_addr};
  assign wr_data = {s1.wr_data, s0.wr_data};

  // Channel 0 = read, channel 1 = write.
  assign ch_req[0] = rd_req;
  assign ch_req[1] = wr_req;
  assign ch_gnt    = {m.wr_gnt, m.rd_gnt};

  genvar c;
  generate
    for (c = 0; c < 2; c++) begin : g_ch
      naive_bus_arb_ch u_arb (
        .clk (clk),
        .rst (rst),
        .req (ch_req[c]),
        .gnt (ch_gnt[c]),
        .win (ch_win[c])
      );
    end
  endgenerate

  assign rw = ch_win[0];
  assign ww = ch_win[1];

  assign m.rd_req  = rd_req[rw];
  assign m.rd_be   = rd_req[rw] ? rd_be[rw]   : '0;
  assign m.rd_addr = rd_req[rw] ? rd_addr[rw] : '0;
  assign m.wr_req  = wr_req[ww];
  assign m.wr_be   = wr_req[ww] ? wr_be[ww]   : '0;
  assign m.wr_addr = wr_req[ww] ? wr_addr[ww] : '0;
  assign m.wr_data = wr_req[ww] ? wr_data[ww] : '0;

  // The loser always sees gnt=0 and retries.
  assign s0.rd_gnt = !rw & m.rd_gnt;
  assign s1.rd_gnt =  rw & m.rd_gnt;
  assign s0.wr_gnt = !ww & m.wr_gnt;
  assign s1.wr_gnt =  ww & m.wr_gnt;

  // Remember who owns the read data returning next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_own_v <= 1'b0;
      rd_own   <= 1'b0;
    end else begin
      rd_own_v <= m.rd_req & m.rd_gnt;
      if (m.rd_req & m.rd_gnt) rd_own <= rw;
    end
  end

  assign s0.rd_data = (rd_own_v && !rd_own) ? m.rd_data : '0;
  assign s1.rd_data = (rd_own_v &&  rd_own) ? m.rd_data : '0;
endmodule

// File: tb/tb_naive_bus_arbiter2.sv
// Bench for naive_bus_arbiter2: reset-relative vector table, directed corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_naive_bus_arbiter2;
`ifdef NAIVE_BUS_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   errs  = 0;

  naive_bus s0_if();
  naive_bus s1_if();
  naive_bus m_if();

  naive_bus_arbiter2 dut (.clk(clk), .rst(rst), .s0(s0_if), .s1(s1_if), .m(m_if));

  always #5 clk = ~clk;

  localparam logic [31:0] RA0 = 32'h0000_0100, RA1 = 32'h0000_1004;
  localparam logic [31:0] WA0 = 32'h0000_0200, WA1 = 32'h0000_2000;
  localparam logic [31:0] WD0 = 32'hAAAA_0000, WD1 = 32'h1234_5678;

  typedef struct {
    logic [1:0]  rq, wq;
    logic        rg, wg;
    logic [1:0]  exp_rg, exp_wg;
    logic [31:0] exp_ra, exp_wa;
    int          exp_own;  // 0/1 = master receiving read data next cycle, 2 = none
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] rq, input logic [1:0] wq, input logic rg, input logic wg);
    s0_if.rd_req = rq[0]; s0_if.rd_addr = RA0; s0_if.rd_be = 4'h3;
    s1_if.rd_req = rq[1]; s1_if.rd_addr = RA1; s1_if.rd_be = 4'hF;
    s0_if.wr_req = wq[0]; s0_if.wr_addr = WA0; s0_if.wr_be = 4'h1; s0_if.wr_data = WD0;
    s1_if.wr_req = wq[1]; s1_if.wr_addr = WA1; s1_if.wr_be = 4'hC; s1_if.wr_data = WD1;
    m_if.rd_gnt = rg; m_if.wr_gnt = wg;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1; #1; rst = 1'b0; #1;
  endtask

  function automatic int pick(input int held, input int pref, input logic [1:0] rq);
    if (held >= 0)     return held;
    if (rq == 2'b01)   return 0;
    if (rq == 2'b10)   return 1;
    return pref;
  endfunction

  vec_t vt[6];

  initial begin
    // Bench-side model state for the randomized phase.
    int held_r, held_w, pref_r, pref_w, ret, wr_, ww_;
    logic [1:0] rq, wq;
    logic rg, wg;
    logic [31:0] ra[2], wa[2], wd[2], md;
    logic [3:0]  rb[2], wb[2];

    vt[0] = '{2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 2};
    vt[1] = '{2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, RA0,   32'h0, 0};
    vt[2] = '{2'b10, 2'b10, 1'b1, 1'b1, 2'b10, 2'b10, RA1,   WA1,   1};
    vt[3] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 2'b01, RA0,   WA0,   0};
    vt[4] = '{2'b10, 2'b01, 1'b1, 1'b1, 2'b10, 2'b01, RA1,   WA0,   1};
    vt[5] = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, RA0,   32'h0, 2};

    rst = 1'b1;
    set_in(2'b00, 2'b00, 1'b0, 1'b0);
    m_if.rd_data = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset s0.rd_data", s0_if.rd_data, 32'h0);
    chk("reset s1.rd_data", s1_if.rd_data, 32'h0);
    chk("reset m.rd_req", {31'h0, m_if.rd_req}, 32'h0);
    chk("reset m.rd_addr", m_if.rd_addr, 32'h0);
    chk("reset m.wr_req", {31'h0, m_if.wr_req}, 32'h0);
    chk("reset m.wr_data", m_if.wr_data, 32'h0);
    rst = 1'b0;

    // Table: every vector starts from the reset state.
    for (int i = 0; i < 6; i++) begin
      rst_pulse();
      set_in(vt[i].rq, vt[i].wq, vt[i].rg, vt[i].wg);
      @(negedge clk);
      chk($sformatf("vec%0d rd_gnt", i), {30'h0, s1_if.rd_gnt, s0_if.rd_gnt}, {30'h0, vt[i].exp_rg});
      chk($sformatf("vec%0d wr_gnt", i), {30'h0, s1_if.wr_gnt, s0_if.wr_gnt}, {30'h0, vt[i].exp_wg});
      chk($sformatf("vec%0d m.rd_addr", i), m_if.rd_addr, vt[i].exp_ra);
      chk($sformatf("vec%0d m.wr_addr", i), m_if.wr_addr, vt[i].exp_wa);
      tick();
      set_in(2'b00, 2'b00, 1'b0, 1'b0);
      m_if.rd_data = 32'hC0DE_0000 | i;
      @(negedge clk);
      chk($sformatf("vec%0d s0.rd_data", i), s0_if.rd_data, (vt[i].exp_own == 0) ? m_if.rd_data : 32'h0);
      chk($sformatf("vec%0d s1.rd_data", i), s1_if.rd_data, (vt[i].exp_own == 1) ? m_if.rd_data : 32'h0);
      tick();
    end

    // Solo read from master 1.
    rst_pulse();
    set_in(2'b10, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    chk("solo m.rd_addr", m_if.rd_addr, 32'h0000_1004);
    chk("solo m.rd_be", {28'h0, m_if.rd_be}, 32'hF);
    chk("solo s1.rd_gnt", {31'h0, s1_if.rd_gnt}, 32'h1);
    tick();
    set_in(2'b00, 2'b00, 1'b0, 1'b0);
    m_if.rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("solo s1.rd_data", s1_if.rd_data, 32'hDEAD_BEEF);
    chk("solo s0.rd_data", s0_if.rd_data, 32'h0);
    tick();

    // Contention: both masters read with the slave always granting.
    rst_pulse();
    for (int k = 0; k < 5; k++) begin
      set_in((k < 4) ? 2'b11 : 2'b00, 2'b00, k < 4, 1'b0);
      m_if.rd_data = 32'h0000_00D0 + k;
      @(negedge clk);
      if (k < 4) begin
        chk($sformatf("cont%0d s0.rd_gnt", k), {31'h0, s0_if.rd_gnt}, (RR && k[0]) ? 32'h0 : 32'h1);
        chk($sformatf("cont%0d s1.rd_gnt", k), {31'h0, s1_if.rd_gnt}, (RR && k[0]) ? 32'h1 : 32'h0);
      end
      if (k > 0) begin
        chk($sformatf("cont%0d s0.rd_data", k), s0_if.rd_data, (RR && !k[0]) ? 32'h0 : m_if.rd_data);
        chk($sformatf("cont%0d s1.rd_data", k), s1_if.rd_data, (RR && !k[0]) ? m_if.rd_data : 32'h0);
      end
      tick();
    end

    // Stall lock on the write channel: s1 stalls, s0 arrives, s1 keeps the bus.
    rst_pulse();
    for (int k = 0; k < 5; k++) begin
      set_in(2'b00, {k < 4, k >= 1}, 1'b0, k >= 3);
      @(negedge clk);
      chk($sformatf("stall%0d m.wr_addr", k), m_if.wr_addr, (k < 4) ? WA1 : WA0);
      chk($sformatf("stall%0d s1.wr_gnt", k), {31'h0, s1_if.wr_gnt}, (k == 3) ? 32'h1 : 32'h0);
      chk($sformatf("stall%0d s0.wr_gnt", k), {31'h0, s0_if.wr_gnt}, (k == 4) ? 32'h1 : 32'h0);
      if (k == 3) chk("stall m.wr_data", m_if.wr_data, WD1);
      tick();
    end

    // Parallel read (s0) and write (s1).
    rst_pulse();
    set_in(2'b01, 2'b10, 1'b1, 1'b1);
    @(negedge clk);
    chk("par s0.rd_gnt", {31'h0, s0_if.rd_gnt}, 32'h1);
    chk("par s1.wr_gnt", {31'h0, s1_if.wr_gnt}, 32'h1);
    tick();
    set_in(2'b00, 2'b00, 1'b0, 1'b0);
    m_if.rd_data = 32'h5A5A_0001;
    @(negedge clk);
    chk("par s0.rd_data", s0_if.rd_data, 32'h5A5A_0001);
    tick();

    // Reset while a read return is in flight drops the data.
    rst_pulse();
    set_in(2'b01, 2'b00, 1'b1, 1'b0);
    tick();
    set_in(2'b00, 2'b00, 1'b0, 1'b0);
    m_if.rd_data = 32'h7777_0000;
    #1;
    chk("ret pre-reset s0.rd_data", s0_if.rd_data, 32'h7777_0000);
    rst = 1'b1; #1;
    chk("ret reset s0.rd_data", s0_if.rd_data, 32'h0);
    rst = 1'b0;
    tick();

    // Reset mid-stall: read lock held on s1, then async reset frees it.
    set_in(2'b10, 2'b00, 1'b0, 1'b0);
    tick();
    set_in(2'b11, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("lock held m.rd_addr", m_if.rd_addr, RA1);
    rst = 1'b1; #1;
    chk("rst mid-stall m.rd_addr", m_if.rd_addr, RA0);
    chk("rst mid-stall s0.rd_data", s0_if.rd_data, 32'h0);
    chk("rst mid-stall s1.rd_data", s1_if.rd_data, 32'h0);
    tick();
    rst = 1'b0;
    set_in(2'b11, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    chk("post-rst s0.rd_gnt", {31'h0, s0_if.rd_gnt}, 32'h1);
    chk("post-rst s1.rd_gnt", {31'h0, s1_if.rd_gnt}, 32'h0);
    tick();

    // Randomized traffic against the rule-level model.
    rst_pulse();
    held_r = -1; held_w = -1; pref_r = 0; pref_w = 0; ret = -1;
    for (int i = 0; i < 400; i++) begin
      rq = {$urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6};
      wq = {$urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6};
      rg = $urandom_range(0, 2) != 0;
      wg = $urandom_range(0, 2) != 0;
      md = $urandom;
      for (int j = 0; j < 2; j++) begin
        ra[j] = $urandom; wa[j] = $urandom; wd[j] = $urandom;
        rb[j] = 4'($urandom); wb[j] = 4'($urandom);
      end
      s0_if.rd_req = rq[0]; s0_if.rd_addr = ra[0]; s0_if.rd_be = rb[0];
      s1_if.rd_req = rq[1]; s1_if.rd_addr = ra[1]; s1_if.rd_be = rb[1];
      s0_if.wr_req = wq[0]; s0_if.wr_addr = wa[0]; s0_if.wr_be = wb[0]; s0_if.wr_data = wd[0];
      s1_if.wr_req = wq[1]; s1_if.wr_addr = wa[1]; s1_if.wr_be = wb[1]; s1_if.wr_data = wd[1];
      m_if.rd_gnt = rg; m_if.wr_gnt = wg; m_if.rd_data = md;
      wr_ = pick(held_r, pref_r, rq);
      ww_ = pick(held_w, pref_w, wq);
      @(negedge clk);
      chk($sformatf("rnd%0d m.rd_req", i), {31'h0, m_if.rd_req}, {31'h0, rq[wr_]});
      chk($sformatf("rnd%0d m.rd_addr", i), m_if.rd_addr, rq[wr_] ? ra[wr_] : 32'h0);
      chk($sformatf("rnd%0d m.rd_be", i), {28'h0, m_if.rd_be}, rq[wr_] ? {28'h0, rb[wr_]} : 32'h0);
      chk($sformatf("rnd%0d s0.rd_gnt", i), {31'h0, s0_if.rd_gnt}, {31'h0, rg && wr_ == 0});
      chk($sformatf("rnd%0d s1.rd_gnt", i), {31'h0, s1_if.rd_gnt}, {31'h0, rg && wr_ == 1});
      chk($sformatf("rnd%0d s0.rd_data", i), s0_if.rd_data, (ret == 0) ? md : 32'h0);
      chk($sformatf("rnd%0d s1.rd_data", i), s1_if.rd_data, (ret == 1) ? md : 32'h0);
      chk($sformatf("rnd%0d m.wr_req", i), {31'h0, m_if.wr_req}, {31'h0, wq[ww_]});
      chk($sformatf("rnd%0d m.wr_addr", i), m_if.wr_addr, wq[ww_] ? wa[ww_] : 32'h0);
      chk($sformatf("rnd%0d m.wr_data", i), m_if.wr_data, wq[ww_] ? wd[ww_] : 32'h0);
      chk($sformatf("rnd%0d m.wr_be", i), {28'h0, m_if.wr_be}, wq[ww_] ? {28'h0, wb[ww_]} : 32'h0);
      chk($sformatf("rnd%0d s0.wr_gnt", i), {31'h0, s0_if.wr_gnt}, {31'h0, wg && ww_ == 0});
      chk($sformatf("rnd%0d s1.wr_gnt", i), {31'h0, s1_if.wr_gnt}, {31'h0, wg && ww_ == 1});
      // Model advance: transfer, stall (hold) or abandon/idle.
      ret = (rq[wr_] && rg) ? wr_ : -1;
      if (rq[wr_] && rg) begin pref_r = RR ? 1 - wr_ : 0; held_r = -1; end
      else if (rq[wr_])  held_r = wr_;
      else               held_r = -1;
      if (wq[ww_] && wg) begin pref_w = RR ? 1 - ww_ : 0; held_w = -1; end
      else if (wq[ww_])  held_w = ww_;
      else               held_w = -1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
